// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/response bundle between execute stage and mdu_iterative
// Ports (master = execute stage, slave = mdu_iterative):
//   start  : request strobe, sampled only while the unit is ready
//   op     : RV32M funct3 (0 MUL .. 7 REMU)
//   inA    : rs1 operand, captured with start
//   inB    : rs2 operand, captured with start
//   flush  : synchronous abort
//   busy   : operation in flight
//   done   : one-cycle result strobe
//   out    : registered result, held until the next done
interface mdu_iterative_if #(
    parameter int N = 32
) ();
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] out;

    modport master (
        output start, op, inA, inB, flush,
        input  busy, done, out
    );

    modport slave (
        input  start, op, inA, inB, flush,
        output busy, done, out
    );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - multi-cycle RV32M multiply/divide unit (shift-add / restoring)
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mdu_iterative_if.slave (start/op/inA/inB/flush in, busy/done/out out)
module mdu_iterative #(
    parameter int N = 32
) (
    input  logic          clock,
    input  logic          reset,
    mdu_iterative_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state;
    state_t         state_nxt;

    logic [2:0]     op_q;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic           sign_a;
    logic           sign_b;
    logic [2*N-1:0] acc;
    logic [4:0]     cnt;
    logic [N-1:0]   out_q;

    logic           ready;
    logic           accept;
    logic           busy_c;
    logic           done_c;

    // operand decode for the request currently on the bus
    logic           in_sa;
    logic           in_sb;
    logic [N-1:0]   in_mag_a;
    logic [N-1:0]   in_mag_b;
    logic           div_zero;
    logic           div_ovf;
    logic           special;
    logic [N-1:0]   special_res;

    // iteration datapath
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_shift;
    logic           div_ge;
    logic [N:0]     div_rem;
    logic [2*N-1:0] div_next;

    // sign fix-up datapath
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;
    logic [N-1:0]   fix_res;

    assign ready  = (state == IDLE) || (state == DONE);
    assign accept = ready && bus.start && !bus.flush;

    always_comb begin
        in_sa = 1'b0;
        in_sb = 1'b0;
        case (bus.op)
            3'd1: begin
                in_sa = bus.inA[N-1];
                in_sb = bus.inB[N-1];
            end
            3'd2: in_sa = bus.inA[N-1];
            3'd4, 3'd6: begin
                in_sa = bus.inA[N-1];
                in_sb = bus.inB[N-1];
            end
            default: ;
        endcase
        // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude
        in_mag_a = in_sa ? -bus.inA : bus.inA;
        in_mag_b = in_sb ? -bus.inB : bus.inB;

        div_zero = bus.op[2] && (bus.inB == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (bus.inA == MIN_NEG) && (bus.inB == '1);
        special  = div_zero || div_ovf;

        if (div_zero) begin
            special_res = bus.op[1] ? bus.inA : '1;
        end else begin
            special_res = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        // multiply: add the partial product into the high half, then shift the
        // whole accumulator right so product bits settle into the low half
        mul_sum  = {1'b0, acc[2*N-1:N]} + (mag_b[cnt] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, acc[N-1:1]};

        // divide: high half is the partial remainder, low half collects quotient
        // bits MSB-first; dividend bits are taken from mag_a MSB-first
        div_shift = {acc[2*N-1:N], mag_a[5'd31 - cnt]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_rem   = div_ge ? (div_shift - {1'b0, mag_b}) : div_shift;
        div_next  = {div_rem[N-1:0], acc[N-2:0], div_ge};
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -acc[N-1:0] : acc[N-1:0];
        rem_fix  = sign_a ? -acc[2*N-1:N] : acc[2*N-1:N];
        case (op_q)
            3'd0:          fix_res = prod_fix[N-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res = prod_fix[2*N-1:N];
            3'd4, 3'd5:    fix_res = quo_fix;
            default:       fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (cnt == 5'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX: state_nxt = bus.flush ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            CALC, FIX: busy_c = 1'b1;
            DONE:      done_c = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            out_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            sign_a <= in_sa;
            sign_b <= in_sb;
            acc    <= '0;
            cnt    <= '0;
            if (special) begin
                out_q <= special_res;
            end
        end else if (state == CALC && !bus.flush) begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 5'd1;
        end else if (state == FIX && !bus.flush) begin
            out_q <= fix_res;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mdu_iterative_if #(.N(32)) bus ();

    mdu_iterative #(.N(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; the following rising edge samples the request
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.inA   = a;
        bus.inB   = b;
        @(posedge clock);
    endtask

    // k counts falling edges after the accepting edge; done at k = latency
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             input logic [31:0] exp_out, input int poke_at);
        int k     = 0;
        int nbusy = 0;
        bit seen  = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clock);
            k++;
            if (k == 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) seen = 1'b1;
            if (poke_at != 0 && k == poke_at) begin
                // a special-case op that would change out at once if accepted
                bus.start = 1'b1;
                bus.op    = 3'd5;
                bus.inA   = 32'd5;
                bus.inB   = 32'd0;
            end
            if (poke_at != 0 && k == poke_at + 1) bus.start = 1'b0;
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        check({tag, " out"}, bus.out, exp_out);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out, input bit spec);
        @(negedge clock);
        issue(op, a, b);
        if (spec) wait_done(tag, 1, 0, exp_out, 0);
        else      wait_done(tag, 34, 33, exp_out, 0);
    endtask

    initial begin
        int ndone;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.inA   = '0;
        bus.inB   = '0;
        bus.flush = 1'b0;

        repeat (2) @(negedge clock);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset out", bus.out, 32'd0);
        reset = 1'b1;

        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mul", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        run_op("div 7/-2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_op("rem 7/-2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("rem -7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_op("divu by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        run_op("remu by0", 3'd7, 32'd5, 32'd0, 32'h00000005, 1'b1);
        run_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);

        // start together with flush while idle must be dropped
        @(negedge clock);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 3'd5;
        bus.inA   = 32'd5;
        bus.inB   = 32'd0;
        @(negedge clock);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle flush busy", {31'd0, bus.busy}, 32'd0);
        check("idle flush done", {31'd0, bus.done}, 32'd0);
        check("idle flush out", bus.out, 32'd0);

        // back-to-back: second start is issued in the DONE cycle
        @(negedge clock);
        issue(3'd5, 32'd100, 32'd7);
        wait_done("divu 100/7", 34, 33, 32'd14, 0);
        issue(3'd7, 32'd100, 32'd7);
        wait_done("b2b remu 100/7", 34, 33, 32'd2, 0);

        // start pulsed mid-CALC is ignored
        @(negedge clock);
        issue(3'd0, 32'd3, 32'd5);
        wait_done("mul poke", 34, 33, 32'd15, 10);

        // flush during the tenth CALC cycle
        @(negedge clock);
        issue(3'd5, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) bus.start = 1'b0;
        end
        check("flush pre busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        check("flush busy drop", {31'd0, bus.busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1) ndone++;
        end
        check("flush no done", 32'(ndone), 32'd0);
        check("flush out kept", bus.out, 32'd15);

        // asynchronous reset mid-CALC
        @(negedge clock);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset done", {31'd0, bus.done}, 32'd0);
        check("midreset out", bus.out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("post-reset mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
